// File: rtl/codebook_stream_writer.sv
// codebook_stream_writer: snapshots NUM_W codebook words on start and streams
// them into the weight RAM write port, one word per cycle, with RAM hold.
module codebook_stream_writer #(
  parameter int NUM_W  = 64,
  parameter int W_BITS = 24,
  parameter int ADDR_W = 18,
  localparam int IDX_W = $clog2(NUM_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    order,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [NUM_W*W_BITS-1:0] weights_flat,
  input  logic                    hold,
  output logic                    busy,
  output logic                    done,
  output logic                    RAM_W_WE,
  output logic [ADDR_W-1:0]       RAM_W_A,
  output logic [W_BITS-1:0]       RAM_W_D
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_W - 1);

  logic [1:0]              state_q, state_d;
  logic [NUM_W*W_BITS-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    order_q, order_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       a_q, a_d;
  logic [W_BITS-1:0]       d_q, d_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Unpack the shadow copy: word 0 sits in the MSBs of the flat bus.
  logic [W_BITS-1:0] words [NUM_W];
  for (genvar k = 0; k < NUM_W; k++) begin : g_unpack
    assign words[k] = shadow_q[(NUM_W-k)*W_BITS-1 -: W_BITS];
  end

  // Descending order only flips which word is read; addresses still ascend.
  logic [IDX_W-1:0] sel;
  assign sel = order_q ? (LAST - idx_q) : idx_q;

  // Next-state logic for the IDLE -> WRITE -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    base_d   = base_q;
    order_d  = order_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    a_d      = a_q;
    d_d      = d_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = weights_flat;
          base_d   = base_addr;
          order_d  = order;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!hold) begin
          we_d  = 1'b1;
          d_d   = words[sel];
          a_d   = base_q + ADDR_W'(idx_q);
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE edge raises done; the second retires busy and returns.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      base_q   <= '0;
      order_q  <= 1'b0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      base_q   <= base_d;
      order_q  <= order_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      a_q      <= a_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign RAM_W_WE = we_q;
  assign RAM_W_A  = a_q;
  assign RAM_W_D  = d_q;

endmodule
